muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 32, meaning the number of clocks the multiplier iterates after its start pulse.
REQ-002 SHALL have parameter DIV_LAT, default 32, meaning the number of clocks the divider iterates after its start pulse.
REQ-003 SHALL have port clk  in  1  system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports op_valid in 1 request valid; op_ready out 1 controller can accept; op_code in 2 (00 MULT, 01 DIV, 10 MTHI, 11 MTLO); op_a in 32 first operand; op_b in 32 second operand.
REQ-006 SHALL have port flush  in  1  abort any in-flight operation.
REQ-007 SHALL have ports unit_a out 32 and unit_b out 32, the latched operands driven to both units.
REQ-008 SHALL have ports mult_start out 1, mult_reset out 1, mult_hi in 32 and mult_lo in 32.
REQ-009 SHALL have ports div_start out 1, div_reset out 1, div_q in 32 (quotient) and div_r in 32 (remainder).
REQ-010 SHALL have ports hi out 32 and lo out 32 (architectural HI/LO), busy out 1, done out 1 (one-cycle commit pulse) and div0 out 1 (one-cycle divide-by-zero pulse).

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN_MUL, RUN_DIV and COMMIT.
REQ-012 SHALL drive op_ready=1 only in IDLE and busy=1 in every other state; an op is accepted on an edge where op_valid&&op_ready.
REQ-013 SHALL, on accepting MULT, latch op_a/op_b into unit_a/unit_b, assert mult_start for exactly one cycle, load the counter with MULT_LAT and enter RUN_MUL.
REQ-014 SHALL, on accepting DIV with op_b!=0, perform the same sequence with div_start and DIV_LAT, entering RUN_DIV.
REQ-015 SHALL, on accepting DIV with op_b==0, pulse div0 for one cycle, issue no start, leave HI/LO unchanged, hold done=0 and remain in IDLE.
REQ-016 SHALL, on accepting MTHI (MTLO), write op_a into hi (lo) at that edge, pulse done the next cycle and remain in IDLE.
REQ-017 SHALL, in RUN_*, decrement the counter once per clock and enter COMMIT on the edge where the counter reaches 0.
REQ-018 SHALL, in COMMIT, assert done, then at the closing edge write hi<=mult_hi, lo<=mult_lo (multiply) or hi<=div_r, lo<=div_q (divide) and return to IDLE.
REQ-019 SHALL update hi/lo MULT_LAT+2 (or DIV_LAT+2) edges after the acceptance edge.
REQ-020 SHALL hold unit_a/unit_b stable from acceptance until the return to IDLE.
REQ-021 SHALL ignore op_valid while busy; no request is queued.
REQ-022 SHALL, when flush=1 in RUN_* or COMMIT, pulse the active unit's *_reset for one cycle, return to IDLE, write neither hi nor lo and hold done=0; flush in IDLE has no effect and takes priority over a same-cycle op_valid.
REQ-023 SHALL hold start, reset, done and div0 pulses to exactly one cycle, and SHALL never assert mult_start and div_start in the same cycle.

Reset
REQ-024 SHALL, while reset=1, set the state to IDLE and force hi=0, lo=0, unit_a=0, unit_b=0, counter=0, busy=0, done=0, div0=0, mult_start=0 and div_start=0.
REQ-025 SHALL assert mult_reset=1 and div_reset=1 while reset=1, so that a reset mid-operation discards the result.
REQ-026 SHALL take reset priority over flush and op_valid.

Structure
REQ-027 SHALL place the op_code encodings, FSM state encodings and default latency constants in shared package muldiv_pkg.
REQ-028 SHALL implement the HI/LO register pair, with its write-select mux, as sub-module muldiv_hilo; the FSM and counter stay in muldiv_ctrl.

Verification
REQ-029 SHALL check MULT with op_a=7, op_b=-3 (0xFFFFFFFD) and unit model at LAT 32 -> mult_start one cycle, done on cycle 33 after acceptance, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-030 SHALL check DIV with op_a=100, op_b=7 -> lo=14, hi=2, done one cycle and busy low afterwards.
REQ-031 SHALL check DIV with op_a=5, op_b=0 -> div0 one cycle, no div_start, hi/lo unchanged and op_ready still 1.
REQ-032 SHALL check flush at cycle 10 of a MULT -> mult_reset one cycle, no done, hi/lo keep their prior values and op_ready=1 the next cycle.
REQ-033 SHALL check that a second op_valid while busy is ignored, and that reset asserted mid-DIV gives hi=lo=0 and state IDLE.
REQ-034 SHALL check MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> hi and lo updated, one done pulse per op.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide controller: op encodings,
// FSM state encoding, HI/LO write selects and default unit latencies.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT = 2'b00,
      OP_DIV  = 2'b01,
      OP_MTHI = 2'b10,
      OP_MTLO = 2'b11
   } op_code_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN_MUL = 2'b01,
      ST_RUN_DIV = 2'b10,
      ST_COMMIT  = 2'b11
   } state_e;

   typedef enum logic [2:0] {
      HL_NONE = 3'd0,
      HL_MTHI = 3'd1,
      HL_MTLO = 3'd2,
      HL_MUL  = 3'd3,
      HL_DIV  = 3'd4
   } hilo_sel_e;

   localparam int DEFAULT_MULT_LAT = 32;
   localparam int DEFAULT_DIV_LAT  = 32;

   // Counter width large enough to hold the larger of the two latencies.
   function automatic int cnt_width(input int lat_a, input int lat_b);
      int m;
      m = (lat_a > lat_b) ? lat_a : lat_b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/muldiv_hilo.sv
// Architectural HI/LO register pair with its write-select mux.
module muldiv_hilo
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  hilo_sel_e   wr_sel,
   input  logic [31:0] wr_a,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   // Select the next HI/LO values: move-to, multiply result or divide result.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      case (wr_sel)
         HL_MTHI: hi_d = wr_a;
         HL_MTLO: lo_d = wr_a;
         HL_MUL: begin
            hi_d = mult_hi;
            lo_d = mult_lo;
         end
         HL_DIV: begin
            hi_d = div_r;   // remainder goes to HI
            lo_d = div_q;   // quotient goes to LO
         end
         default: ;
      endcase
   end

   // HI/LO state, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for an iterative multiplier and divider.
//
// Request handshake: an op is taken on a rising edge where
// op_valid && op_ready (and flush is low). op_ready is high only in IDLE;
// requests presented while busy are dropped, never queued.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MULT_LAT = DEFAULT_MULT_LAT,
   parameter int DIV_LAT  = DEFAULT_DIV_LAT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [1:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        mult_start,
   output logic        mult_reset,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   output logic        div_start,
   output logic        div_reset,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div0,
   output state_e      dbg_state
);

   localparam int CNT_W = cnt_width(MULT_LAT, DIV_LAT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      unit_a_q, unit_a_d;
   logic [31:0]      unit_b_q, unit_b_d;
   logic             mult_start_q, mult_start_d;
   logic             div_start_q, div_start_d;
   logic             mult_rst_q, mult_rst_d;
   logic             div_rst_q, div_rst_d;
   logic             div0_q, div0_d;
   logic             mt_done_q, mt_done_d;
   logic             op_div_q, op_div_d;
   logic             accept;
   hilo_sel_e        hilo_sel;

   // Next-state, counter, operand latch, pulse and HI/LO write-select logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      unit_a_d     = unit_a_q;
      unit_b_d     = unit_b_q;
      op_div_d     = op_div_q;
      mult_start_d = 1'b0;
      div_start_d  = 1'b0;
      mult_rst_d   = 1'b0;
      div_rst_d    = 1'b0;
      div0_d       = 1'b0;
      mt_done_d    = 1'b0;
      hilo_sel     = HL_NONE;
      // flush in IDLE does nothing itself but blocks a same-cycle request
      accept       = op_valid && (state_q == ST_IDLE) && !flush;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op_code)
                  OP_MULT: begin
                     unit_a_d     = op_a;
                     unit_b_d     = op_b;
                     mult_start_d = 1'b1;
                     cnt_d        = CNT_W'(MULT_LAT);
                     op_div_d     = 1'b0;
                     state_d      = ST_RUN_MUL;
                  end
                  OP_DIV: begin
                     if (op_b == '0) begin
                        // divide by zero: flag it, start nothing, stay idle
                        div0_d = 1'b1;
                     end else begin
                        unit_a_d    = op_a;
                        unit_b_d    = op_b;
                        div_start_d = 1'b1;
                        cnt_d       = CNT_W'(DIV_LAT);
                        op_div_d    = 1'b1;
                        state_d     = ST_RUN_DIV;
                     end
                  end
                  OP_MTHI: begin
                     hilo_sel  = HL_MTHI;
                     mt_done_d = 1'b1;
                  end
                  default: begin
                     hilo_sel  = HL_MTLO;
                     mt_done_d = 1'b1;
                  end
               endcase
            end
         end
         ST_RUN_MUL, ST_RUN_DIV: begin
            if (flush) begin
               mult_rst_d = !op_div_q;
               div_rst_d  = op_div_q;
               state_d    = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_COMMIT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_COMMIT: begin
            if (flush) begin
               mult_rst_d = !op_div_q;
               div_rst_d  = op_div_q;
            end else begin
               hilo_sel = op_div_q ? HL_DIV : HL_MUL;
            end
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         unit_a_q     <= '0;
         unit_b_q     <= '0;
         op_div_q     <= 1'b0;
         mult_start_q <= 1'b0;
         div_start_q  <= 1'b0;
         mult_rst_q   <= 1'b0;
         div_rst_q    <= 1'b0;
         div0_q       <= 1'b0;
         mt_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         unit_a_q     <= unit_a_d;
         unit_b_q     <= unit_b_d;
         op_div_q     <= op_div_d;
         mult_start_q <= mult_start_d;
         div_start_q  <= div_start_d;
         mult_rst_q   <= mult_rst_d;
         div_rst_q    <= div_rst_d;
         div0_q       <= div0_d;
         mt_done_q    <= mt_done_d;
      end
   end

   muldiv_hilo u_hilo (
      .clk     (clk),
      .reset   (reset),
      .wr_sel  (hilo_sel),
      .wr_a    (op_a),
      .mult_hi (mult_hi),
      .mult_lo (mult_lo),
      .div_q   (div_q),
      .div_r   (div_r),
      .hi      (hi),
      .lo      (lo)
   );

   // Pulses are suppressed while reset is high; unit resets follow reset
   // directly so an in-flight unit result is discarded.
   assign op_ready   = (state_q == ST_IDLE);
   assign busy       = !op_ready;
   assign mult_start = mult_start_q && !reset;
   assign div_start  = div_start_q && !reset;
   assign mult_reset = reset || mult_rst_q;
   assign div_reset  = reset || div_rst_q;
   assign div0       = div0_q && !reset;
   assign done       = !reset && (mt_done_q || ((state_q == ST_COMMIT) && !flush));
   assign unit_a     = unit_a_q;
   assign unit_b     = unit_b_q;
   assign dbg_state  = state_q;

endmodule
